uart_alu_intf: RTL and testbench
================================

# uart_alu_intf

Downstream consumer of `uart_rx`. Assembles three received bytes into an ALU command: operand A, operand B, then opcode. Drives the operands and opcode to an external combinational ALU, captures the result, and hands it to the UART transmitter with a start/busy handshake. Sits between `uart_rx` (input side) and `uart_tx` (output side) in the UART–ALU loop.

## Interface
Parameters:
- `NB_DATA_BITS`, 8: width of a UART data byte, operands and result.
- `NB_OP`, 6: opcode width; taken from the low bits of the opcode byte.
- `TIMEOUT_CYCLES`, 1000000: inter-byte timeout in clk cycles. Used only with `UART_ALU_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_rx_data` in NB_DATA_BITS: byte from `uart_rx`; valid while `i_rx_done` is high.
- `i_rx_done` in 1: one-cycle pulse; a new byte is present.
- `o_data_a` out NB_DATA_BITS: registered operand A to ALU.
- `o_data_b` out NB_DATA_BITS: registered operand B to ALU.
- `o_op` out NB_OP: registered opcode to ALU.
- `i_alu_result` in NB_DATA_BITS: combinational ALU result.
- `o_tx_data` out NB_DATA_BITS: captured result to `uart_tx`.
- `o_tx_start` out 1: one-cycle registered pulse; start transmission.
- `i_tx_busy` in 1: transmitter busy; no start is issued while high.
- `o_drop` out 1: one-cycle pulse; a received byte was discarded.
- `o_timeout` out 1: one-cycle pulse; frame abandoned by timeout. Tied to 0 without the macro.

## Operation
- FSM states: S_A, S_B, S_OP, S_LATCH, S_SEND. Reset state is S_A.
- S_A: on `i_rx_done`, `o_data_a` is loaded from `i_rx_data`; go to S_B.
- S_B: on `i_rx_done`, `o_data_b` is loaded; go to S_OP.
- S_OP: on `i_rx_done`, `o_op` is loaded from `i_rx_data[NB_OP-1:0]` (upper bits ignored); go to S_LATCH.
- S_LATCH: exactly one cycle. The ALU settles on the registered inputs. `o_tx_data` is loaded from `i_alu_result`; go to S_SEND.
- S_SEND:
  - If `i_tx_busy` is 0, assert `o_tx_start` for the next cycle and go to S_A.
  - Otherwise stay in S_SEND indefinitely.
- Bytes arriving in S_LATCH or S_SEND are discarded and `o_drop` pulses. State and registers are unaffected.
- Operand and opcode registers hold their values until overwritten by the next frame.
- Reset clears all outputs to 0 and the state to S_A immediately, at any point mid-frame.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `i_rx_done` on the opcode byte is sampled at edge E0. Result capture happens at E1. If `i_tx_busy` is 0 at E2, `o_tx_start` is high for the one cycle after E2.
- Busy-to-start latency: start is issued 1 cycle after the first cycle in which `i_tx_busy` is sampled low in S_SEND.
- `o_tx_start` is exactly one cycle wide, one pulse per frame. `o_tx_data` is stable from E1 until the next S_LATCH.
- `o_drop` and `o_timeout` each pulse for one cycle, one cycle after the triggering edge.
- `i_rx_done` in the same cycle as the timeout expiry: the byte wins, the counter clears, no timeout.
- Throughput is limited by the UART byte rate. The FSM never back-pressures `uart_rx`.

## Configuration
- Macro `UART_ALU_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in S_B and S_OP.
  - It clears on every `i_rx_done` and on entry to S_B.
  - On reaching TIMEOUT_CYCLES-1 without a byte, the FSM returns to S_A and `o_timeout` pulses.
  - Operand registers keep their stale values.
- Undefined: no counter; S_B and S_OP wait forever; `o_timeout` is constant 0.

## Test plan
- Frame A=0x05, B=0x03, op=0x20, ALU model add, `i_tx_busy`=0 -> `o_data_a`=0x05, `o_data_b`=0x03, `o_op`=6'h20, `o_tx_data`=0x08, single `o_tx_start` pulse 3 edges after the opcode `i_rx_done`.
- Same frame with `i_tx_busy` held high for 10 cycles after S_SEND entry -> no start during busy; exactly one pulse 1 cycle after busy falls.
- Extra byte 0xAA injected in S_SEND -> `o_drop` pulse, `o_tx_data` unchanged; next frame 0x10, 0x01, 0x20 yields 0x11.
- `i_rst_n` pulsed low after A and B received -> all outputs 0 immediately; next three bytes 0x07, 0x02, 0x22 form a fresh frame with `o_op`=6'h22.
- Opcode byte 0xE2 -> `o_op`=6'h22 (truncation).
- With `UART_ALU_TIMEOUT_EN` and TIMEOUT_CYCLES=50: send A only, idle 50 cycles -> `o_timeout` pulse, state S_A; the following byte loads `o_data_a`. Without the macro, the same stimulus gives no timeout, and the next byte loads `o_data_b`.

Source files
------------

// File: rtl/uart_alu_intf.sv
// ============================================================================
// Module   : uart_alu_intf
// Brief    : Collects A, B and opcode bytes from uart_rx, drives an external
//            ALU, captures its result and starts uart_tx. Optional inter-byte
//            timeout is enabled with macro UART_ALU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_alu_intf #(
   parameter int NB_DATA_BITS   = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    i_rst_n,
   input  logic [NB_DATA_BITS-1:0] i_rx_data,
   input  logic                    i_rx_done,
   output logic [NB_DATA_BITS-1:0] o_data_a,
   output logic [NB_DATA_BITS-1:0] o_data_b,
   output logic [NB_OP-1:0]        o_op,
   input  logic [NB_DATA_BITS-1:0] i_alu_result,
   output logic [NB_DATA_BITS-1:0] o_tx_data,
   output logic                    o_tx_start,
   input  logic                    i_tx_busy,
   output logic                    o_drop,
   output logic                    o_timeout
);

   typedef enum logic [2:0] {
      S_A     = 3'd0,
      S_B     = 3'd1,
      S_OP    = 3'd2,
      S_LATCH = 3'd3,
      S_SEND  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   w_load_a;
   logic   w_load_b;
   logic   w_load_op;
   logic   w_capture;
   logic   w_start;
   logic   w_drop;
   logic   w_timeout;

`ifdef UART_ALU_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               w_waiting;

   // Counter is zero outside S_B/S_OP, so entry to S_B always starts from 0.
   assign w_waiting = (r_state == S_B) || (r_state == S_OP);
   assign w_timeout = w_waiting && !i_rx_done && (r_cnt == c_CNT_LAST);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_waiting && !i_rx_done && !w_timeout) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end
`else
   // Never true: frames wait indefinitely for their remaining bytes.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      w_load_op    = 1'b0;
      w_capture    = 1'b0;
      w_start      = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         S_A: begin
            if (i_rx_done) begin
               w_load_a     = 1'b1;
               w_state_next = S_B;
            end
         end
         S_B: begin
            if (i_rx_done) begin
               w_load_b     = 1'b1;
               w_state_next = S_OP;
            end else if (w_timeout) begin
               w_state_next = S_A;
            end
         end
         S_OP: begin
            if (i_rx_done) begin
               w_load_op    = 1'b1;
               w_state_next = S_LATCH;
            end else if (w_timeout) begin
               w_state_next = S_A;
            end
         end
         S_LATCH: begin
            // ALU inputs have been registered for a full cycle by now.
            w_capture    = 1'b1;
            w_drop       = i_rx_done;
            w_state_next = S_SEND;
         end
         S_SEND: begin
            w_drop = i_rx_done;
            if (!i_tx_busy) begin
               w_start      = 1'b1;
               w_state_next = S_A;
            end
         end
         default: begin
            w_state_next = S_A;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data_a   <= '0;
         o_data_b   <= '0;
         o_op       <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_drop     <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         if (w_load_a)  o_data_a  <= i_rx_data;
         if (w_load_b)  o_data_b  <= i_rx_data;
         if (w_load_op) o_op      <= i_rx_data[NB_OP-1:0];
         if (w_capture) o_tx_data <= i_alu_result;
         o_tx_start <= w_start;
         o_drop     <= w_drop;
         o_timeout  <= w_timeout;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_intf.sv
// ============================================================================
// Module   : tb_uart_alu_intf
// Brief    : Self-checking bench for uart_alu_intf: frame-level reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_alu_intf;

   localparam int c_TO = 50;

   logic       clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_rx_done = 1'b0;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic [7:0] i_alu_result;
   logic [7:0] o_tx_data;
   logic       o_tx_start;
   logic       i_tx_busy = 1'b0;
   logic       o_drop;
   logic       o_timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int n_timeout_pulses = 0;

   uart_alu_intf #(
      .NB_DATA_BITS  (8),
      .NB_OP         (6),
      .TIMEOUT_CYCLES(c_TO)
   ) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_done   (i_rx_done),
      .o_data_a    (o_data_a),
      .o_data_b    (o_data_b),
      .o_op        (o_op),
      .i_alu_result(i_alu_result),
      .o_tx_data   (o_tx_data),
      .o_tx_start  (o_tx_start),
      .i_tx_busy   (i_tx_busy),
      .o_drop      (o_drop),
      .o_timeout   (o_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign i_alu_result = alu(o_data_a, o_data_b, o_op);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: frame position plus a result-pending flag.
   int         m_pos = 0;      // bytes of the current frame received, 3 = result pending
   bit         m_captured = 0;
   int         m_wait = 0;
   logic [7:0] m_a = 0, m_b = 0, m_tx = 0;
   logic [5:0] m_op = 0;
   bit         m_start = 0, m_drop = 0, m_timeout = 0;

   always @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_pos = 0; m_captured = 0; m_wait = 0;
         m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
         m_start = 0; m_drop = 0; m_timeout = 0;
      end else begin
         m_start = 0; m_drop = 0; m_timeout = 0;
         if (m_pos == 3) begin
            if (i_rx_done) m_drop = 1;
            if (!m_captured) begin
               m_tx = alu(m_a, m_b, m_op);
               m_captured = 1;
            end else if (!i_tx_busy) begin
               m_start = 1;
               m_pos = 0;
            end
         end else if (i_rx_done) begin
            case (m_pos)
               0:       m_a = i_rx_data;
               1:       m_b = i_rx_data;
               default: m_op = i_rx_data[5:0];
            endcase
            m_pos++;
            m_wait = 0;
            m_captured = 0;
         end else if (m_pos > 0) begin
`ifdef UART_ALU_TIMEOUT_EN
            m_wait++;
            if (m_wait == c_TO) begin
               m_timeout = 1;
               m_pos = 0;
               m_wait = 0;
            end
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("data_a", 32'(o_data_a), 32'(m_a));
      chk("data_b", 32'(o_data_b), 32'(m_b));
      chk("op", 32'(o_op), 32'(m_op));
      chk("tx_data", 32'(o_tx_data), 32'(m_tx));
      chk("tx_start", 32'(o_tx_start), 32'(m_start));
      chk("drop", 32'(o_drop), 32'(m_drop));
      chk("timeout", 32'(o_timeout), 32'(m_timeout));
      if (o_timeout) n_timeout_pulses++;
   end

   // Inputs change 2 ns after the edge; outputs read on return reflect that edge.
   task automatic step(input bit done, input logic [7:0] d, input bit busy);
      @(posedge clk);
      #2;
      i_rx_done = done;
      i_rx_data = d;
      i_tx_busy = busy;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input bit busy);
      step(1, a, busy);
      step(1, b, busy);
      step(1, op, busy);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      i_rst_n = 1'b0;
      i_rx_done = 1'b0;
      i_tx_busy = 1'b0;
      #1;
      chk("rst_data_a", 32'(o_data_a), 32'h0);
      chk("rst_data_b", 32'(o_data_b), 32'h0);
      chk("rst_op", 32'(o_op), 32'h0);
      chk("rst_tx_data", 32'(o_tx_data), 32'h0);
      chk("rst_start", 32'(o_tx_start), 32'h0);
      @(posedge clk);
      #2;
      i_rst_n = 1'b1;
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      logic [7:0] ops [5];
      ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'hE2;

      do_reset();
      chk("after_reset_drop", 32'(o_drop), 32'h0);

      // Basic add frame, transmitter idle.
      send3(8'h05, 8'h03, 8'h20, 0);
      step(0, 0, 0);
      chk("t1_op", 32'(o_op), 32'h20);
      chk("t1_start_e0", 32'(o_tx_start), 32'h0);
      step(0, 0, 0);
      chk("t1_tx_data", 32'(o_tx_data), 32'h08);
      chk("t1_start_e1", 32'(o_tx_start), 32'h0);
      step(0, 0, 0);
      chk("t1_start_e2", 32'(o_tx_start), 32'h1);
      chk("t1_data_a", 32'(o_data_a), 32'h05);
      chk("t1_data_b", 32'(o_data_b), 32'h03);
      step(0, 0, 0);
      chk("t1_start_width", 32'(o_tx_start), 32'h0);

      // Transmitter busy for 10 cycles after entering S_SEND.
      send3(8'h05, 8'h03, 8'h20, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, (i < 9));
         chk("t2_no_start_busy", 32'(o_tx_start), 32'h0);
      end
      step(0, 0, 0);
      chk("t2_start_after_busy", 32'(o_tx_start), 32'h1);
      step(0, 0, 0);
      chk("t2_single_pulse", 32'(o_tx_start), 32'h0);

      // Extra byte while waiting in S_SEND.
      send3(8'h05, 8'h03, 8'h20, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      step(1, 8'hAA, 1);
      step(0, 0, 1);
      chk("t3_drop", 32'(o_drop), 32'h1);
      chk("t3_tx_kept", 32'(o_tx_data), 32'h08);
      step(0, 0, 0);
      chk("t3_drop_width", 32'(o_drop), 32'h0);
      step(0, 0, 0);
      chk("t3_start", 32'(o_tx_start), 32'h1);
      send3(8'h10, 8'h01, 8'h20, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t3_next_result", 32'(o_tx_data), 32'h11);
      step(0, 0, 0);
      step(0, 0, 0);

      // Reset mid-frame after A and B.
      step(1, 8'h55, 0);
      step(1, 8'h66, 0);
      step(0, 0, 0);
      chk("t4_a_loaded", 32'(o_data_a), 32'h55);
      do_reset();
      send3(8'h07, 8'h02, 8'h22, 0);
      step(0, 0, 0);
      chk("t4_op", 32'(o_op), 32'h22);
      chk("t4_a", 32'(o_data_a), 32'h07);
      step(0, 0, 0);
      chk("t4_result", 32'(o_tx_data), 32'h05);
      step(0, 0, 0);
      step(0, 0, 0);

      // Opcode truncation.
      send3(8'h09, 8'h04, 8'hE2, 0);
      step(0, 0, 0);
      chk("t5_trunc_op", 32'(o_op), 32'h22);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);

      // Lone A byte followed by a long idle period.
      step(1, 8'h33, 0);
      for (int i = 0; i < c_TO + 5; i++) step(0, 0, 0);
      step(1, 8'h44, 0);
      step(0, 0, 0);
`ifdef UART_ALU_TIMEOUT_EN
      chk("t6_timeout_seen", 32'(n_timeout_pulses), 32'h1);
      chk("t6_reload_a", 32'(o_data_a), 32'h44);
`else
      chk("t6_no_timeout", 32'(n_timeout_pulses), 32'h0);
      chk("t6_load_b", 32'(o_data_b), 32'h44);
      chk("t6_keep_a", 32'(o_data_a), 32'h33);
`endif
      do_reset();

      // Randomized frames with idle gaps, busy periods and stray bytes.
      for (int f = 0; f < 200; f++) begin
         for (int b = 0; b < 3; b++) begin
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) step(0, 8'($urandom), ($urandom_range(0, 2) == 0));
            if (b == 2) step(1, ops[$urandom_range(0, 4)], ($urandom_range(0, 2) == 0));
            else        step(1, 8'($urandom), ($urandom_range(0, 2) == 0));
         end
         gap = $urandom_range(2, 12);
         for (int g = 0; g < gap; g++)
            step(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
         // Idle until any pending result has gone out.
         for (int g = 0; g < 4; g++) step(0, 0, 0);
      end

      step(0, 0, 0);
      step(0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
